// File: rtl/nios_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM state encoding,
// Avalon word addresses, data width and default expected words.
package nios_sysid_pkg;

   localparam int DATA_W = 32;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   localparam logic [DATA_W-1:0] DEF_EXPECTED_ID = 32'd4919;
   localparam logic [DATA_W-1:0] DEF_EXPECTED_TS = 32'd1542894059;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_ID = 3'd1,
      LAT_ID = 3'd2,
      REQ_TS = 3'd3,
      LAT_TS = 3'd4,
      FIN    = 3'd5
   } state_t;

endpackage

// File: rtl/nios_sysid_rd_port.sv
// Single-word Avalon-MM read engine. The sequencing FSM tells it which phase
// the current read is in (request or fixed-latency wait). It reports the
// accept, the capture strobe with its data, and an abort when the per-read
// timer reaches TIMEOUT_CYCLES. A capture in the last allowed cycle wins
// over the abort.
module nios_sysid_rd_port
   import nios_sysid_pkg::*;
#(
   parameter int READ_LATENCY   = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_phase,
   input  logic              lat_phase,
   input  logic              waitrequest,
   input  logic [DATA_W-1:0] readdata,
   output logic              accept,
   output logic              cap_valid,
   output logic [DATA_W-1:0] cap_data,
   output logic              tmo
);

   localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam int LAT_LAST_I = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
   localparam logic [1:0] LAT_LAST = 2'(LAT_LAST_I);

   logic [TMR_W-1:0] timer;
   logic [1:0]       lat_cnt;

   // Handshake: the slave accepts the request in the cycle where waitrequest is low.
   assign accept    = req_phase & ~waitrequest;
   assign cap_valid = (READ_LATENCY == 0) ? accept
                                          : (lat_phase & (lat_cnt == LAT_LAST));
   assign cap_data  = readdata;
   assign tmo       = (req_phase | lat_phase) & ~cap_valid & (timer == TMR_LAST);

   // Counts cycles elapsed since the accept edge while waiting for read data.
   always_ff @(posedge clock) begin
      if (reset || accept) begin
         lat_cnt <= '0;
      end else if (lat_phase) begin
         lat_cnt <= lat_cnt + 2'd1;
      end
   end

   // Per-read timer: zero whenever no read is open, restarts after each capture or abort.
   always_ff @(posedge clock) begin
      if (reset || !(req_phase || lat_phase) || cap_valid || tmo) begin
         timer <= '0;
      end else begin
         timer <= timer + TMR_W'(1);
      end
   end

endmodule

// File: rtl/nios_sysid_checker.sv
// System-ID checker: Avalon-MM read master that fetches the system ID
// (address 0) and build timestamp (address 1) and compares them against
// expected values. Only one read is ever outstanding and the timestamp read
// is issued only after the ID read completes.
// Optional feature: define NIOS_SYSID_PERIODIC_EN to add a 24-bit free-running
// counter that self-starts a check on every wrap while idle.
module nios_sysid_checker
   import nios_sysid_pkg::*;
#(
   parameter logic [DATA_W-1:0] EXPECTED_ID    = DEF_EXPECTED_ID,
   parameter logic [DATA_W-1:0] EXPECTED_TS    = DEF_EXPECTED_TS,
   parameter int                READ_LATENCY   = 0,
   parameter int                TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              av_address,
   output logic              av_read,
   input  logic              av_waitrequest,
   input  logic [DATA_W-1:0] av_readdata,
   output logic              busy,
   output logic              done,
   output logic              id_ok,
   output logic              ts_ok,
   output logic              timeout,
   output logic [DATA_W-1:0] id_value,
   output logic [DATA_W-1:0] ts_value
);

   state_t            state;
   state_t            state_next;
   logic              start_eff;
   logic              req_phase;
   logic              lat_phase;
   logic              id_phase;
   logic              ts_phase;
   logic              accept;
   logic              cap_valid;
   logic [DATA_W-1:0] cap_data;
   logic              tmo;

`ifdef NIOS_SYSID_PERIODIC_EN
   logic [23:0] period_cnt;

   // Free-running wrap counter; its all-ones cycle requests a self-check.
   always_ff @(posedge clock) begin
      if (reset) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + 24'd1;
      end
   end

   assign start_eff = start | (&period_cnt);
`else
   assign start_eff = start;
`endif

   assign req_phase = (state == REQ_ID) || (state == REQ_TS);
   assign lat_phase = (state == LAT_ID) || (state == LAT_TS);
   assign id_phase  = (state == REQ_ID) || (state == LAT_ID);
   assign ts_phase  = (state == REQ_TS) || (state == LAT_TS);

   // Avalon valid/ready: av_read is held with a stable av_address for every REQ
   // cycle; the transfer is accepted in the cycle av_waitrequest is low.
   assign av_read    = req_phase;
   assign av_address = ts_phase ? ADDR_TS : ADDR_ID;
   assign busy       = (state != IDLE);
   assign done       = (state == FIN);

   nios_sysid_rd_port #(
      .READ_LATENCY   (READ_LATENCY),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rd_port (
      .clock       (clock),
      .reset       (reset),
      .req_phase   (req_phase),
      .lat_phase   (lat_phase),
      .waitrequest (av_waitrequest),
      .readdata    (av_readdata),
      .accept      (accept),
      .cap_valid   (cap_valid),
      .cap_data    (cap_data),
      .tmo         (tmo)
   );

   // Sequencing FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: ID read, then TS read, then a one-cycle FIN; an abort skips to FIN.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start_eff) state_next = REQ_ID;
         end
         REQ_ID: begin
            if (cap_valid)   state_next = REQ_TS;
            else if (tmo)    state_next = FIN;
            else if (accept) state_next = LAT_ID;
         end
         LAT_ID: begin
            if (cap_valid) state_next = REQ_TS;
            else if (tmo)  state_next = FIN;
         end
         REQ_TS: begin
            if (cap_valid || tmo) state_next = FIN;
            else if (accept)      state_next = LAT_TS;
         end
         LAT_TS: begin
            if (cap_valid || tmo) state_next = FIN;
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Result registers: cleared on an accepted start, loaded on each capture, sticky abort flag.
   always_ff @(posedge clock) begin
      if (reset || (state == IDLE && start_eff)) begin
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         timeout  <= 1'b0;
         id_value <= '0;
         ts_value <= '0;
      end else begin
         if (cap_valid && id_phase) begin
            id_value <= cap_data;
            id_ok    <= (cap_data == EXPECTED_ID);
         end
         if (cap_valid && ts_phase) begin
            ts_value <= cap_data;
            ts_ok    <= (cap_data == EXPECTED_TS);
         end
         if (tmo) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Bench for nios_sysid_checker. Two instances share one bus model: instance 0
// with a zero-latency slave, instance 1 with a two-cycle-latency slave; both
// abort reads after 8 cycles. Expected behaviour of every transaction is
// planned arithmetically from the slave's stall count and latency, then
// compared cycle by cycle on the falling edge.
module tb_nios_sysid_checker;

   localparam int N_INST = 2;
   localparam int TMO    = 8;
   localparam logic [31:0] EXP_ID = 32'd4919;
   localparam logic [31:0] EXP_TS = 32'd1542894059;

   typedef struct {
      int          done_k;  // cycle (start cycle = 0) in which done must be high
      int          id_e;    // last cycle of the ID request (first is cycle 1)
      int          ts_s;    // first cycle of the TS request
      int          ts_e;    // last cycle of the TS request
      int          id_vis;  // first cycle the captured ID is visible (0 = never)
      int          ts_vis;  // first cycle the captured TS is visible (0 = never)
      int          tmo_vis; // first cycle timeout is visible (0 = never)
      logic [31:0] did;
      logic [31:0] dts;
   } plan_t;

   typedef struct {
      logic        id_ok;
      logic        ts_ok;
      logic        tmo;
      logic [31:0] idv;
      logic [31:0] tsv;
   } res_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        start          [N_INST];
   logic        av_address     [N_INST];
   logic        av_read        [N_INST];
   logic        av_waitrequest [N_INST];
   logic [31:0] av_readdata    [N_INST];
   logic        busy           [N_INST];
   logic        done           [N_INST];
   logic        id_ok          [N_INST];
   logic        ts_ok          [N_INST];
   logic        timeout        [N_INST];
   logic [31:0] id_value       [N_INST];
   logic [31:0] ts_value       [N_INST];

   plan_t pl          [N_INST];
   res_t  prev        [N_INST];
   bit    active      [N_INST];
   int    base        [N_INST];
   int    rd_cnt      [N_INST];
   int    done_cnt    [N_INST];
   int    last_done_k [N_INST];

   logic [31:0] exp_q[$];
   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   for (genvar g = 0; g < N_INST; g++) begin : g_dut
      nios_sysid_checker #(
         .EXPECTED_ID    (EXP_ID),
         .EXPECTED_TS    (EXP_TS),
         .READ_LATENCY   (2 * g),
         .TIMEOUT_CYCLES (TMO)
      ) u_dut (
         .clock          (clock),
         .reset          (reset),
         .start          (start[g]),
         .av_address     (av_address[g]),
         .av_read        (av_read[g]),
         .av_waitrequest (av_waitrequest[g]),
         .av_readdata    (av_readdata[g]),
         .busy           (busy[g]),
         .done           (done[g]),
         .id_ok          (id_ok[g]),
         .ts_ok          (ts_ok[g]),
         .timeout        (timeout[g]),
         .id_value       (id_value[g]),
         .ts_value       (ts_value[g])
      );
   end

   // ---------------- model ----------------
   function automatic int min2(int a, int b);
      return (a < b) ? a : b;
   endfunction

   // A read occupies (stalls + 1) request cycles plus n latency cycles and
   // must fit within TMO cycles; otherwise it aborts after exactly TMO cycles.
   function automatic plan_t make_plan(int n, int wid, int wts, logic [31:0] did, logic [31:0] dts);
      plan_t p;
      int tid;
      int tts;
      p.did = did;
      p.dts = dts;
      p.id_vis = 0;
      p.ts_vis = 0;
      p.tmo_vis = 0;
      p.ts_s = 1;
      p.ts_e = 0;
      tid = wid + 1 + n;
      p.id_e = min2(wid + 1, TMO);
      if (tid > TMO) begin
         p.tmo_vis = TMO + 1;
         p.done_k = TMO + 1;
      end else begin
         p.id_vis = tid + 1;
         p.ts_s = tid + 1;
         p.ts_e = tid + min2(wts + 1, TMO);
         tts = wts + 1 + n;
         if (tts > TMO) begin
            p.tmo_vis = tid + TMO + 1;
            p.done_k = p.tmo_vis;
         end else begin
            p.ts_vis = tid + tts + 1;
            p.done_k = p.ts_vis;
         end
      end
      return p;
   endfunction

   function automatic res_t res_at(plan_t p, int k);
      res_t r;
      r.idv   = (p.id_vis != 0 && k >= p.id_vis) ? p.did : 32'd0;
      r.id_ok = (p.id_vis != 0 && k >= p.id_vis) && (p.did == EXP_ID);
      r.tsv   = (p.ts_vis != 0 && k >= p.ts_vis) ? p.dts : 32'd0;
      r.ts_ok = (p.ts_vis != 0 && k >= p.ts_vis) && (p.dts == EXP_TS);
      r.tmo   = (p.tmo_vis != 0 && k >= p.tmo_vis);
      return r;
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", name, g, cyc, got, exp);
      end
   endtask

   task automatic chkb(input string name, input int g, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc%0d: got %b expected %b", name, g, cyc, got, exp);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clock) begin
      if (chk_en) begin
         for (int g = 0; g < N_INST; g++) begin
            int    k;
            res_t  e;
            plan_t p;
            logic  eb, ed, er, ea;
            k = cyc - base[g];
            p = pl[g];
            if (active[g] && k >= 1) begin
               e  = res_at(p, k);
               eb = (k <= p.done_k);
               ed = (k == p.done_k);
               er = (k <= p.id_e) || (k >= p.ts_s && k <= p.ts_e);
               ea = (k >= p.ts_s && k <= p.ts_e);
               if (av_read[g] === 1'b1) rd_cnt[g]++;
               if (done[g] === 1'b1) last_done_k[g] = k;
            end else begin
               e  = prev[g];
               eb = 1'b0;
               ed = 1'b0;
               er = 1'b0;
               ea = 1'b0;
            end
            chkb("busy", g, busy[g], eb);
            chkb("done", g, done[g], ed);
            chkb("av_read", g, av_read[g], er);
            if (er) chkb("av_address", g, av_address[g], ea);
            chkb("id_ok", g, id_ok[g], e.id_ok);
            chkb("ts_ok", g, ts_ok[g], e.ts_ok);
            chkb("timeout", g, timeout[g], e.tmo);
            chk("id_value", g, id_value[g], e.idv);
            chk("ts_value", g, ts_value[g], e.tsv);
            if (done[g] === 1'b1) begin
               done_cnt[g]++;
               if (exp_q.size() >= 2) begin
                  chk("done_id_value", g, id_value[g], exp_q.pop_front());
                  chk("done_ts_value", g, ts_value[g], exp_q.pop_front());
               end else begin
                  chk("exp_q_depth", g, exp_q.size(), 2);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Slave behaviour for cycle k of the running transaction: stall the planned
   // number of cycles, present data in the capture cycle, random elsewhere.
   task automatic drive_slave(input int g, input int k, input int wid, input int wts);
      plan_t p;
      logic w;
      logic [31:0] d;
      p = pl[g];
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (k >= 1 && k <= wid) w = 1'b1;
      else if (k == wid + 1) w = 1'b0;
      if (p.id_vis != 0) begin
         if (k >= p.ts_s && k < p.ts_s + wts) w = 1'b1;
         else if (k == p.ts_s + wts) w = 1'b0;
      end
      if (p.id_vis != 0 && k == p.id_vis - 1) d = p.did;
      if (p.ts_vis != 0 && k == p.ts_vis - 1) d = p.dts;
      av_waitrequest[g] = w;
      av_readdata[g] = d;
   endtask

   // One check on instance g. spam: 0 no extra starts, 1 random, 2 every busy
   // cycle (including the done cycle). rst_k > 0 pulses reset in that cycle.
   task automatic run_txn(input int g, input int wid, input int wts, input logic [31:0] did,
                          input logic [31:0] dts, input int spam, input int rst_k);
      plan_t p;
      res_t fin;
      p = make_plan(2 * g, wid, wts, did, dts);
      fin = res_at(p, p.done_k);
      @(posedge clock); #1;
      pl[g] = p;
      base[g] = cyc;
      active[g] = 1'b1;
      rd_cnt[g] = 0;
      done_cnt[g] = 0;
      last_done_k[g] = -1;
      exp_q.push_back(fin.idv);
      exp_q.push_back(fin.tsv);
      start[g] = 1'b1;
      drive_slave(g, 0, wid, wts);
      for (int k = 1; k <= p.done_k + 1; k++) begin
         @(posedge clock); #1;
         if (rst_k > 0 && k == rst_k + 1) begin
            reset = 1'b0;
            start[g] = 1'b0;
            for (int gg = 0; gg < N_INST; gg++) begin
               active[gg] = 1'b0;
               prev[gg] = '{default: '0};
            end
            exp_q.delete();
            return;
         end
         if (k == p.done_k + 1) begin
            active[g] = 1'b0;
            prev[g] = fin;
            start[g] = 1'b0;
         end else begin
            if (spam == 2) start[g] = 1'b1;
            else if (spam == 1) start[g] = 1'($urandom_range(0, 1));
            else start[g] = 1'b0;
            reset = (k == rst_k);
            drive_slave(g, k, wid, wts);
         end
      end
      chk("done_once", g, done_cnt[g], 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      for (int g = 0; g < N_INST; g++) begin
         start[g] = 1'b0;
         av_waitrequest[g] = 1'b0;
         av_readdata[g] = '0;
         prev[g] = '{default: '0};
         base[g] = 0;
         last_done_k[g] = -1;
      end
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      chk_en = 1'b1;

      // reset state
      @(negedge clock);
      chkb("rst_busy", 0, busy[0], 1'b0);
      chkb("rst_av_read", 1, av_read[1], 1'b0);
      chk("rst_id_value", 0, id_value[0], 32'd0);

      // zero-latency slave, matching image
      run_txn(0, 0, 0, EXP_ID, EXP_TS, 0, 0);
      chk("t1_done_cycle", 0, last_done_k[0], 3);
      chkb("t1_id_ok", 0, id_ok[0], 1'b1);
      chkb("t1_ts_ok", 0, ts_ok[0], 1'b1);
      chkb("t1_timeout", 0, timeout[0], 1'b0);

      // wrong ID word
      run_txn(0, 0, 0, 32'd4920, EXP_TS, 0, 0);
      chk("t2_id_value", 0, id_value[0], 32'd4920);
      chkb("t2_id_ok", 0, id_ok[0], 1'b0);
      chkb("t2_ts_ok", 0, ts_ok[0], 1'b1);

      // 5 stall cycles per read, latency 2: exactly fills the 8-cycle budget
      run_txn(1, 5, 5, EXP_ID, EXP_TS, 0, 0);
      chk("t3_done_cycle", 1, last_done_k[1], 17);
      chk("t3_read_cycles", 1, rd_cnt[1], 12);
      chkb("t3_ts_ok", 1, ts_ok[1], 1'b1);

      // waitrequest stuck high: abort after 8 request cycles, no TS read
      run_txn(1, 40, 0, EXP_ID, EXP_TS, 0, 0);
      chk("t4_read_cycles", 1, rd_cnt[1], 8);
      chk("t4_done_cycle", 1, last_done_k[1], 9);
      chkb("t4_timeout", 1, timeout[1], 1'b1);
      chkb("t4_id_ok", 1, id_ok[1], 1'b0);

      // zero-latency budget boundary: 7 stalls fit, 8 stalls abort
      run_txn(0, 7, 0, EXP_ID, EXP_TS, 0, 0);
      chkb("t4b_fit_timeout", 0, timeout[0], 1'b0);
      run_txn(0, 8, 0, EXP_ID, EXP_TS, 0, 0);
      chkb("t4b_over_timeout", 0, timeout[0], 1'b1);

      // reset pulsed while the TS request is stalled
      run_txn(1, 0, 30, EXP_ID, EXP_TS, 0, 6);
      chkb("t5_av_read", 1, av_read[1], 1'b0);
      chkb("t5_busy", 1, busy[1], 1'b0);
      chkb("t5_id_ok", 1, id_ok[1], 1'b0);
      chk("t5_id_value", 1, id_value[1], 32'd0);
      run_txn(1, 0, 0, EXP_ID, EXP_TS, 0, 0);
      chkb("t5_fresh_id_ok", 1, id_ok[1], 1'b1);
      chkb("t5_fresh_ts_ok", 1, ts_ok[1], 1'b1);

      // start held through busy and the done cycle: one check only
      run_txn(0, 2, 1, EXP_ID, EXP_TS, 2, 0);
      run_txn(1, 1, 2, EXP_ID, EXP_TS, 2, 0);

      // randomized transactions on both instances
      for (int t = 0; t < 60; t++) begin
         int g;
         int wid;
         int wts;
         logic [31:0] did;
         logic [31:0] dts;
         g = t % N_INST;
         wid = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
         wts = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
         case ($urandom_range(0, 2))
            0: did = EXP_ID;
            1: did = EXP_ID ^ (32'd1 << $urandom_range(0, 31));
            default: did = $urandom;
         endcase
         case ($urandom_range(0, 2))
            0: dts = EXP_TS;
            1: dts = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
            default: dts = $urandom;
         endcase
         run_txn(g, wid, wts, did, dts, $urandom_range(0, 2), 0);
         repeat ($urandom_range(0, 2)) @(posedge clock);
      end

`ifdef NIOS_SYSID_PERIODIC_EN
      begin
         bit seen;
         chk_en = 1'b0;
         av_waitrequest[0] = 1'b0;
         @(posedge clock); #1;
         force g_dut[0].u_dut.period_cnt = 24'hFFFFFF;
         @(posedge clock); #1;
         release g_dut[0].u_dut.period_cnt;
         seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done[0] === 1'b1) seen = 1'b1;
         end
         chkb("periodic_done", 0, seen, 1'b1);
      end
`endif

      @(posedge clock); #1;
      chk("exp_q_empty", 0, exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
